branch_resolve_ctrl: RTL and testbench

- ID-stage sequencer for the branch comparator. Holds a branch in ID while its operands are still in flight.
- Stalls the front end the required number of cycles, then resolves the branch from the comparator's taken flag.
- Drives PC-source select, IF/ID write-enable, IF/ID flush and ID/EX bubble.
- Sits between the hazard-detection logic, the comparator and the PC/IF-ID pipeline registers, and keeps branch statistics counters.

---
 rtl/branch_resolve_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
//
// ID-stage sequencer for the branch comparator. When a conditional branch sits
// in ID while one of its source operands is still being produced further down
// the pipe, the front end is frozen (PC and IF/ID held, bubble into ID/EX) for
// the required number of cycles. The branch is then resolved from the
// comparator's taken flag. Unconditional jumps redirect immediately.
// Saturating counters keep branch statistics.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   id_branch    in   conditional branch present in ID
//   id_jump      in   unconditional jump present in ID (beats id_branch)
//   cmp_taken    in   comparator taken flag, sampled only when resolving
//   hz_ex_alu    in   EX ALU op writes a branch source (1 stall)
//   hz_mem_load  in   MEM load writes a branch source (1 stall)
//   hz_ex_load   in   EX load writes a branch source (2 stalls)
//   pc_write     out  PC write enable
//   ifid_write   out  IF/ID write enable
//   ifid_flush   out  zero IF/ID on the next edge
//   idex_bubble  out  insert NOP into ID/EX on the next edge
//   pc_src       out  0 = PC+4, 1 = branch target, 2 = jump target
//   branch_cnt   out  branches resolved (saturating)
//   taken_cnt    out  branches resolved taken (saturating)
//   stall_cnt    out  stall cycles inserted (saturating)
//   dbg_state    out  current FSM state: 0 = IDLE, 1 = STALL, 2 = RESOLVE
//
// Handshake: there is no valid/ready pair here. id_branch/id_jump act as a
// "valid" for the instruction in ID; pc_write/ifid_write low acts as the
// "not ready" back-pressure to the front end. An instruction is consumed on
// any edge where pc_write is high.
// -----------------------------------------------------------------------------
module branch_resolve_ctrl #(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             cmp_taken,
  input  logic             hz_ex_alu,
  input  logic             hz_mem_load,
  input  logic             hz_ex_load,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       pc_src,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_state
);

  // Down-counter is wide enough to hold MAX_STALL; never narrower than 1 bit.
  localparam int SC_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

  localparam logic [SC_W-1:0]  SC_ONE   = SC_W'(1);
  localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = '1;

  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_JUMP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STALL   = 2'd1,
    S_RESOLVE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SC_W-1:0]   scnt_q, scnt_d;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [1:0]        n_raw;
  logic [SC_W-1:0]   n_need;
  logic [SC_W-1:0]   n_minus1;
  logic              br_inc, tk_inc, st_inc;

  // Stall requirement from the hazard inputs, clamped to MAX_STALL.
  always_comb begin
    n_raw = 2'd0;
    if (hz_ex_load) begin
      n_raw = 2'd2;
    end else if (hz_ex_alu || hz_mem_load) begin
      n_raw = 2'd1;
    end
    if (int'(n_raw) > MAX_STALL) begin
      n_need = SC_MAX;
    end else begin
      n_need = SC_W'(n_raw);
    end
    n_minus1 = n_need - SC_ONE;
  end

  // Next state and Mealy outputs.
  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pc_src      = PC_SEQ;
    br_inc      = 1'b0;
    tk_inc      = 1'b0;
    st_inc      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (id_jump) begin
          pc_src     = PC_JUMP;
          ifid_flush = 1'b1;
        end else if (id_branch) begin
          if (n_need == '0) begin
            br_inc = 1'b1;
            if (cmp_taken) begin
              pc_src     = PC_BR;
              ifid_flush = 1'b1;
              tk_inc     = 1'b1;
            end
          end else begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            st_inc      = 1'b1;
            scnt_d      = n_minus1;
            state_d     = (n_minus1 != '0) ? S_STALL : S_RESOLVE;
          end
        end
      end

      S_STALL: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        st_inc      = 1'b1;
        scnt_d      = (scnt_q != '0) ? (scnt_q - SC_ONE) : '0;
        // Last stall cycle when the counter is about to hit zero.
        if (scnt_q <= SC_ONE) begin
          state_d = S_RESOLVE;
        end
      end

      S_RESOLVE: begin
        // Resolves even if id_branch dropped; the branch is still counted.
        br_inc = 1'b1;
        if (cmp_taken) begin
          pc_src     = PC_BR;
          ifid_flush = 1'b1;
          tk_inc     = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        scnt_d  = '0;
      end
    endcase

    // While reset is held the outputs sit at their quiet defaults regardless
    // of what the pipeline is presenting.
    if (!reset) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pc_src      = PC_SEQ;
      br_inc      = 1'b0;
      tk_inc      = 1'b0;
      st_inc      = 1'b0;
    end
  end

  // Saturating statistics counters.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (br_inc && (branch_cnt_q != CNT_FULL)) begin
      branch_cnt_d = branch_cnt_q + CNT_ONE;
    end
    if (tk_inc && (taken_cnt_q != CNT_FULL)) begin
      taken_cnt_d = taken_cnt_q + CNT_ONE;
    end
    if (st_inc && (stall_cnt_q != CNT_FULL)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      scnt_q       <= '0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      scnt_q       <= scnt_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//
// Directed bench for branch_resolve_ctrl. Two instances share all inputs: one
// with the default 16-bit counters and one with 2-bit counters to exercise
// saturation. Inputs change on the falling edge; outputs are sampled 1 ns
// later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

  logic clk;
  logic reset;
  logic id_branch, id_jump, cmp_taken;
  logic hz_ex_alu, hz_mem_load, hz_ex_load;

  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0]  pc_src, dbg_state;
  logic [15:0] branch_cnt, taken_cnt, stall_cnt;

  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble;
  logic [1:0]  s_pc_src, s_dbg_state;
  logic [1:0]  s_branch_cnt, s_taken_cnt, s_stall_cnt;

  int n_tests;
  int n_fail;

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUTs
  branch_resolve_ctrl #(.CNT_W(16), .MAX_STALL(2)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .id_branch   (id_branch),
    .id_jump     (id_jump),
    .cmp_taken   (cmp_taken),
    .hz_ex_alu   (hz_ex_alu),
    .hz_mem_load (hz_mem_load),
    .hz_ex_load  (hz_ex_load),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .pc_src      (pc_src),
    .branch_cnt  (branch_cnt),
    .taken_cnt   (taken_cnt),
    .stall_cnt   (stall_cnt),
    .dbg_state   (dbg_state)
  );

  branch_resolve_ctrl #(.CNT_W(2), .MAX_STALL(2)) u_sat (
    .clk         (clk),
    .reset       (reset),
    .id_branch   (id_branch),
    .id_jump     (id_jump),
    .cmp_taken   (cmp_taken),
    .hz_ex_alu   (hz_ex_alu),
    .hz_mem_load (hz_mem_load),
    .hz_ex_load  (hz_ex_load),
    .pc_write    (s_pc_write),
    .ifid_write  (s_ifid_write),
    .ifid_flush  (s_ifid_flush),
    .idex_bubble (s_idex_bubble),
    .pc_src      (s_pc_src),
    .branch_cnt  (s_branch_cnt),
    .taken_cnt   (s_taken_cnt),
    .stall_cnt   (s_stall_cnt),
    .dbg_state   (s_dbg_state)
  );

  // ---------------------------------------------------------------- checks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic pcw, input logic ifw,
                          input logic fl, input logic bub, input logic [1:0] src);
    chk({tag, ".pc_write"},    32'(pc_write),    32'(pcw));
    chk({tag, ".ifid_write"},  32'(ifid_write),  32'(ifw));
    chk({tag, ".ifid_flush"},  32'(ifid_flush),  32'(fl));
    chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bub));
    chk({tag, ".pc_src"},      32'(pc_src),      32'(src));
  endtask

  task automatic chk_cnts(input string tag, input int br, input int tk, input int st);
    chk({tag, ".branch_cnt"}, 32'(branch_cnt), 32'(br));
    chk({tag, ".taken_cnt"},  32'(taken_cnt),  32'(tk));
    chk({tag, ".stall_cnt"},  32'(stall_cnt),  32'(st));
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic drive(input logic br, input logic jmp, input logic tk,
                       input logic alu, input logic mld, input logic eld);
    @(negedge clk);
    id_branch   = br;
    id_jump     = jmp;
    cmp_taken   = tk;
    hz_ex_alu   = alu;
    hz_mem_load = mld;
    hz_ex_load  = eld;
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b0;
    id_branch   = 1'b0;
    id_jump     = 1'b0;
    cmp_taken   = 1'b0;
    hz_ex_alu   = 1'b0;
    hz_mem_load = 1'b0;
    hz_ex_load  = 1'b0;

    // Reset held for 3 cycles with random inputs.
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle_cycle();
    chk_outs("rst_held", 1, 1, 0, 0, 2'd0);
    chk_cnts("rst_held", 0, 0, 0);
    reset = 1'b1;
    idle_cycle();
    chk_outs("rst_rel", 1, 1, 0, 0, 2'd0);
    chk_cnts("rst_rel", 0, 0, 0);
    chk("rst_rel.state", 32'(dbg_state), 32'd0);

    // Branch, no hazard, taken: resolves in cycle 0.
    drive(1, 0, 1, 0, 0, 0);
    chk_outs("br_nohz_tk", 1, 1, 1, 0, 2'd1);
    idle_cycle();
    chk_outs("br_nohz_after", 1, 1, 0, 0, 2'd0);
    chk_cnts("br_nohz_tk", 1, 1, 0);

    // Branch with EX ALU hazard, not taken: one stall then resolve.
    drive(1, 0, 0, 1, 0, 0);
    chk_outs("alu_c0", 0, 0, 0, 1, 2'd0);
    drive(1, 0, 0, 1, 0, 0);
    chk("alu_c1.state", 32'(dbg_state), 32'd2);
    chk_outs("alu_c1", 1, 1, 0, 0, 2'd0);
    idle_cycle();
    chk_cnts("alu_nt", 2, 1, 1);

    // Branch with EX load hazard; taken only in the resolve cycle.
    drive(1, 0, 0, 0, 0, 1);
    chk_outs("eld_c0", 0, 0, 0, 1, 2'd0);
    drive(1, 0, 0, 0, 0, 1);
    chk("eld_c1.state", 32'(dbg_state), 32'd1);
    chk_outs("eld_c1", 0, 0, 0, 1, 2'd0);
    drive(1, 0, 1, 0, 0, 1);
    chk_outs("eld_c2", 1, 1, 1, 0, 2'd1);
    idle_cycle();
    chk_cnts("eld_tk", 3, 2, 3);
    chk("eld_done.state", 32'(dbg_state), 32'd0);

    // Jump together with branch: jump wins, branch not counted.
    drive(1, 1, 1, 0, 0, 0);
    chk_outs("jmp_br", 1, 1, 1, 0, 2'd2);
    // Jump with a hazard present: still no stall.
    drive(1, 1, 0, 0, 0, 1);
    chk_outs("jmp_hz", 1, 1, 1, 0, 2'd2);
    idle_cycle();
    chk_cnts("jmp", 3, 2, 3);

    // MEM load hazard, taken, followed immediately by a no-hazard branch.
    drive(1, 0, 0, 0, 1, 0);
    chk_outs("mld_c0", 0, 0, 0, 1, 2'd0);
    drive(1, 0, 1, 0, 1, 0);
    chk_outs("mld_c1", 1, 1, 1, 0, 2'd1);
    drive(1, 0, 0, 0, 0, 0);
    chk_outs("b2b", 1, 1, 0, 0, 2'd0);
    idle_cycle();
    chk_cnts("b2b", 5, 3, 4);

    // id_branch drops in RESOLVE: still resolved and counted.
    drive(1, 0, 0, 1, 0, 0);
    chk_outs("drop_c0", 0, 0, 0, 1, 2'd0);
    drive(0, 0, 1, 0, 0, 0);
    chk_outs("drop_c1", 1, 1, 1, 0, 2'd1);
    idle_cycle();
    chk_cnts("drop", 6, 4, 5);

    // Reset in the second stall cycle of an EX load branch.
    drive(1, 0, 0, 0, 0, 1);
    chk_outs("rmid_c0", 0, 0, 0, 1, 2'd0);
    drive(1, 0, 1, 0, 0, 1);
    chk("rmid_c1.state", 32'(dbg_state), 32'd1);
    reset = 1'b0;
    #1;
    chk_outs("rmid_rst", 1, 1, 0, 0, 2'd0);
    chk_cnts("rmid_rst", 0, 0, 0);
    chk("rmid_rst.state", 32'(dbg_state), 32'd0);
    drive(1, 0, 1, 0, 0, 0);
    chk_outs("rmid_hold", 1, 1, 0, 0, 2'd0);
    idle_cycle();
    reset = 1'b1;
    idle_cycle();
    chk_outs("rmid_rel", 1, 1, 0, 0, 2'd0);
    chk_cnts("rmid_rel", 0, 0, 0);

    // Five taken branches: 2-bit counters saturate at 3.
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 0, 0, 0);
    end
    idle_cycle();
    chk("sat.taken_cnt",  32'(s_taken_cnt),  32'd3);
    chk("sat.branch_cnt", 32'(s_branch_cnt), 32'd3);
    chk("sat.stall_cnt",  32'(s_stall_cnt),  32'd0);
    chk_cnts("wide5", 5, 5, 0);

    // Three more stalls on the narrow instance: stall_cnt saturates too.
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    idle_cycle();
    chk("sat.stall_cnt2", 32'(s_stall_cnt), 32'd3);
    chk("sat.taken_hold", 32'(s_taken_cnt), 32'd3);
    chk_cnts("wide7", 7, 5, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
